// File: rtl/pingpong_drain_pkg.sv
// pingpong_drain_pkg: shared state encoding, FIFO depth and pointer helper for the ping-pong drain
package pingpong_drain_pkg;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FIFO_DEPTH = 3;
  typedef enum logic [1:0] {
    WAIT_BANK = 2'b00,
    DRAIN     = 2'b01,
    FLUSH     = 2'b10,
    RELEASE   = 2'b11
  } state_t;
  function automatic logic [1:0] fifo_inc(logic [1:0] p);
    return p == 2'(FIFO_DEPTH - 1) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/pingpong_drain_sync_fifo.sv
// sync_fifo: 3-entry output FIFO with occupancy, async active-high reset
module sync_fifo
  import pingpong_drain_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ,
  output logic         empty
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0] wp, rp;
  // storage needs no reset; validity is tracked by occ
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      wp  <= push ? fifo_inc(wp) : wp;
      rp  <= pop ? fifo_inc(rp) : rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
  assign dout  = mem[rp];
  assign empty = occ == 2'd0;
endmodule

// File: rtl/pingpong_drain.sv
// pingpong_drain: drains full ping-pong banks in alternation into a valid/ready stream
module pingpong_drain
  import pingpong_drain_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bank_full,
  output logic [1:0]        bank_release,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_done
);
  state_t state, nxt;
  logic cur, inflight, last_q, empty, last_addr;
  logic [ADDR_W-1:0] addr;
  logic [1:0] occ;
  logic [DATA_W:0] head;
  logic [2:0] credit;
  assign last_addr = addr == ADDR_W'(DEPTH - 1);
  // words already committed to the FIFO; issue only while a slot is guaranteed
  assign credit = {1'b0, occ} + {2'b0, inflight};
  assign rd_en = state == DRAIN && credit < 3'(FIFO_DEPTH);
  assign rd_bank = cur;
  assign rd_addr = addr;
  assign frame_done = state == RELEASE;
  assign bank_release = frame_done ? (cur ? 2'b10 : 2'b01) : 2'b00;
  assign m_valid = !empty;
  assign m_data = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last = m_valid & head[DATA_W];
  // next-state: only the bank whose turn it is can start a frame
  always_comb begin
    nxt = state;
    unique case (state)
      WAIT_BANK: nxt = bank_full[cur] ? DRAIN : WAIT_BANK;
      DRAIN:     nxt = rd_en && last_addr ? FLUSH : DRAIN;
      FLUSH:     nxt = !inflight && empty ? RELEASE : FLUSH;
      RELEASE:   nxt = WAIT_BANK;
    endcase
  end
  // state, bank pointer, address counter and read-latency tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= WAIT_BANK;
      cur      <= 1'b0;
      addr     <= '0;
      inflight <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state    <= nxt;
      cur      <= state == RELEASE ? !cur : cur;
      addr     <= rd_en ? addr + 1'b1 : addr;
      inflight <= rd_en;
      last_q   <= rd_en && last_addr;
    end
  sync_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  ({last_q, rd_data}),
    .pop  (m_valid & m_ready),
    .dout (head),
    .occ  (occ),
    .empty(empty)
  );
endmodule
